// File: rtl/hazard_stall_ctrl.sv
// ID/EX hazard and stall controller: load-use stalls, multi-cycle EX freezes, branch flushes.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 16,
  localparam int MAX_LAT = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT,
  localparam int SC_W    = $clog2(MAX_LAT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             busy,
  output logic [SC_W-1:0]  stall_cnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_stall_cycles,
  output logic [CNT_W-1:0] stat_flushes
`endif
);

  typedef enum logic [1:0] {IDLE, LD_STALL, MC_STALL} state_t;

  // The trigger cycle itself is the first stall cycle, so the stall state only covers the rest.
  localparam int LD_RELOAD = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 0;
  localparam int MC_RELOAD = (MC_LAT > 2) ? MC_LAT - 2 : 0;

  state_t          stateReg, stateNext;
  logic [SC_W-1:0] cntReg, cntNext;
  logic            luHit, mcHit;

  assign luHit = ex_mem_read && (ex_rd != '0) &&
                 ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  assign mcHit = ex_mc_start && (MC_LAT > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (ex_branch_taken) begin
          stateNext = IDLE;
        end else if (mcHit) begin
          if (MC_LAT > 2) begin
            stateNext = MC_STALL;
            cntNext   = SC_W'(MC_RELOAD);
          end
        end else if (luHit && (LOAD_LAT > 1)) begin
          stateNext = LD_STALL;
          cntNext   = SC_W'(LD_RELOAD);
        end
      end
      LD_STALL, MC_STALL: begin
        cntNext = cntReg - SC_W'(1);
        if (cntReg == SC_W'(1)) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Outputs are forced to their idle values while reset is held, regardless of inputs.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (rst_n) begin
      case (stateReg)
        IDLE: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (mcHit) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
          end else if (luHit) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        LD_STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        MC_STALL: begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (stateReg != IDLE);
  assign stall_cnt = cntReg;

`ifdef HAZARD_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
      stat_flushes      <= '0;
    end else begin
      if (!pc_en && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + CNT_W'(1);
      if (ifid_flush && (stat_flushes != '1))
        stat_flushes <= stat_flushes + CNT_W'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: two instances (A: LOAD_LAT=1/MC_LAT=4, B: LOAD_LAT=3/MC_LAT=2)
// share one stimulus stream; HAZARD_STATS_EN adds counter checks.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken, ex_mc_start;

  logic       aPc, aIfidEn, aFlush, aIdexEn, aIdexBub, aExBub, aBusy;
  logic [2:0] aCnt;
  logic       bPc, bIfidEn, bFlush, bIdexEn, bIdexBub, bExBub, bBusy;
  logic [2:0] bCnt;
`ifdef HAZARD_STATS_EN
  logic [15:0] aStall, aFlushes, bStall, bFlushes;
`endif

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .MC_LAT(4), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
    .pc_en(aPc), .ifid_en(aIfidEn), .ifid_flush(aFlush), .idex_en(aIdexEn),
    .idex_bubble(aIdexBub), .exmem_bubble(aExBub), .busy(aBusy), .stall_cnt(aCnt)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(aStall), .stat_flushes(aFlushes)
`endif
  );

  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .MC_LAT(2), .CNT_W(16)) dutB (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
    .pc_en(bPc), .ifid_en(bIfidEn), .ifid_flush(bFlush), .idex_en(bIdexEn),
    .idex_bubble(bIdexBub), .exmem_bubble(bExBub), .busy(bBusy), .stall_cnt(bCnt)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(bStall), .stat_flushes(bFlushes)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and checked before the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
  endtask

  task automatic chkDefault(input string tag);
    $display("step %s", tag);
    chk({tag, " A pc_en"}, aPc, 1);      chk({tag, " A idex_en"}, aIdexEn, 1);
    chk({tag, " A flush"}, aFlush, 0);   chk({tag, " A idex_bub"}, aIdexBub, 0);
    chk({tag, " A ex_bub"}, aExBub, 0);  chk({tag, " A busy"}, aBusy, 0);
    chk({tag, " B pc_en"}, bPc, 1);      chk({tag, " B idex_en"}, bIdexEn, 1);
    chk({tag, " B flush"}, bFlush, 0);   chk({tag, " B idex_bub"}, bIdexBub, 0);
    chk({tag, " B ex_bub"}, bExBub, 0);  chk({tag, " B busy"}, bBusy, 0);
    chk({tag, " A cnt"}, aCnt, 0);       chk({tag, " B cnt"}, bCnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clearIn();
    #3;
    chkDefault("reset");
    chk("reset A ifid_en", aIfidEn, 1);
`ifdef HAZARD_STATS_EN
    chk("reset A stat_stall", aStall, 0); chk("reset A stat_flush", aFlushes, 0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
    #1 chkDefault("idle");

    // Load-use on rs: A stalls 1 cycle, B stalls 3 cycles.
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    #1 $display("step lu cycle1");
    chk("lu1 A pc_en", aPc, 0);      chk("lu1 A ifid_en", aIfidEn, 0);
    chk("lu1 A idex_bub", aIdexBub, 1); chk("lu1 A idex_en", aIdexEn, 1);
    chk("lu1 A busy", aBusy, 0);
    chk("lu1 B pc_en", bPc, 0);      chk("lu1 B idex_bub", bIdexBub, 1);
    chk("lu1 B busy", bBusy, 0);
    tick();
    clearIn(); ex_branch_taken = 1'b1;
    #1 $display("step lu cycle2 with branch");
    chk("lu2 A pc_en", aPc, 1);      chk("lu2 A flush", aFlush, 1);
    chk("lu2 A idex_bub", aIdexBub, 1); chk("lu2 A busy", aBusy, 0);
    chk("lu2 B pc_en", bPc, 0);      chk("lu2 B flush", bFlush, 0);
    chk("lu2 B idex_bub", bIdexBub, 1); chk("lu2 B busy", bBusy, 1);
    chk("lu2 B cnt", bCnt, 2);
    tick();
    clearIn();
    #1 $display("step lu cycle3");
    chk("lu3 B pc_en", bPc, 0);      chk("lu3 B cnt", bCnt, 1);
    chk("lu3 A pc_en", aPc, 1);
    tick();
    #1 chkDefault("lu done");

    // Multi-cycle op: A freezes 3 cycles, B (MC_LAT=2) freezes only the start cycle.
    tick();
    ex_mc_start = 1'b1;
    #1 $display("step mc cycle1");
    chk("mc1 A idex_en", aIdexEn, 0); chk("mc1 A ex_bub", aExBub, 1);
    chk("mc1 A pc_en", aPc, 0);       chk("mc1 A busy", aBusy, 0);
    chk("mc1 B idex_en", bIdexEn, 0); chk("mc1 B ex_bub", bExBub, 1);
    tick();
    ex_mc_start = 1'b0; ex_branch_taken = 1'b1;
    #1 $display("step mc cycle2 with branch");
    chk("mc2 A idex_en", aIdexEn, 0); chk("mc2 A ex_bub", aExBub, 1);
    chk("mc2 A flush", aFlush, 0);    chk("mc2 A busy", aBusy, 1);
    chk("mc2 A cnt", aCnt, 2);
    chk("mc2 B flush", bFlush, 1);    chk("mc2 B idex_en", bIdexEn, 1);
    chk("mc2 B busy", bBusy, 0);
    tick();
    ex_branch_taken = 1'b0;
    #1 $display("step mc cycle3");
    chk("mc3 A idex_en", aIdexEn, 0); chk("mc3 A cnt", aCnt, 1);
    tick();
    #1 chkDefault("mc done");

    // Branch beats a simultaneous load-use and multi-cycle start.
    tick();
    ex_branch_taken = 1'b1; ex_mc_start = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    #1 $display("step branch priority");
    chk("br A flush", aFlush, 1);   chk("br A idex_bub", aIdexBub, 1);
    chk("br A pc_en", aPc, 1);      chk("br A idex_en", aIdexEn, 1);
    chk("br A ex_bub", aExBub, 0);
    chk("br B flush", bFlush, 1);   chk("br B pc_en", bPc, 1);
    tick();
    clearIn();
    #1 chkDefault("br after");

    // No hazard on register 0, nor when the matching source is unused.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1 $display("step reg0");
    chk("r0 A pc_en", aPc, 1); chk("r0 B pc_en", bPc, 1); chk("r0 A idex_bub", aIdexBub, 0);
    ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b0;
    #1 $display("step unused rs");
    chk("nouse A pc_en", aPc, 1); chk("nouse B pc_en", bPc, 1);
    ex_rd = 5'd8; id_rs = 5'd3; id_use_rs = 1'b1; id_rt = 5'd8; id_use_rt = 1'b1;
    #1 $display("step rt hazard");
    chk("rt A pc_en", aPc, 0); chk("rt B idex_bub", bIdexBub, 1);
    tick();
    clearIn();
    #1 chk("rt2 B busy", bBusy, 1);
    tick(); tick();
    #1 chkDefault("rt done");

    // Reset during the second MC_STALL cycle.
    tick();
    ex_mc_start = 1'b1;
    tick();
    ex_mc_start = 1'b0;
    #1 chk("rst pre A busy", aBusy, 1);
    rst_n = 1'b0; ex_branch_taken = 1'b1;
    #1 chkDefault("mid reset");
    chk("mid reset A ifid_en", aIfidEn, 1);
`ifdef HAZARD_STATS_EN
    chk("mid reset A stat_stall", aStall, 0); chk("mid reset A stat_flush", aFlushes, 0);
    chk("mid reset B stat_stall", bStall, 0); chk("mid reset B stat_flush", bFlushes, 0);
`endif
    ex_branch_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    #1 chkDefault("post reset");

`ifdef HAZARD_STATS_EN
    // One flush cycle, then one A-stall (lu) cycle that B turns into three.
    tick();
    ex_branch_taken = 1'b1;
    tick();
    clearIn(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    tick();
    clearIn();
    tick(); tick();
    #1 $display("step stats");
    chk("stat A flush", aFlushes, 1); chk("stat A stall", aStall, 1);
    chk("stat B flush", bFlushes, 1); chk("stat B stall", bStall, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised hazard and stall controller for the 5-stage pipelined datapath, ID/EX stage boundary. Detects load-use hazards and holds the front end for a configurable number of cycles (LOAD_LAT). Freezes the pipeline for multi-cycle EX operations such as the SAD unit (MC_LAT). Flushes wrong-path instructions on a taken branch resolved in EX.

Parameters:
REG_W, 5, register-address width
LOAD_LAT, 1, stall cycles per load-use hazard (legal range >=1)
MC_LAT, 4, total EX occupancy of a multi-cycle op in cycles (legal range >=1)
CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
id_rs  in  REG_W  source register 1 of the instruction in ID
id_rt  in  REG_W  source register 2 of the instruction in ID
id_use_rs  in  1  ID instruction reads id_rs
id_use_rt  in  1  ID instruction reads id_rt
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_W  destination register of the instruction in EX
ex_branch_taken  in  1  branch in EX resolved taken
ex_mc_start  in  1  multi-cycle op entered EX this cycle
pc_en  out  1  1 = PC updates
ifid_en  out  1  1 = IF/ID register loads
ifid_flush  out  1  1 = IF/ID loads a NOP
idex_en  out  1  1 = ID/EX register loads
idex_bubble  out  1  1 = ID/EX loads a NOP (control bits cleared)
exmem_bubble  out  1  1 = EX/MEM loads a NOP
busy  out  1  1 = FSM not in IDLE
stall_cnt  out  $clog2(max(LOAD_LAT,MC_LAT))+1  remaining stall-state cycles

Behaviour:
- States: IDLE, LD_STALL, MC_STALL. Internal down-counter cnt.
- Reset (async, rst_n low): state=IDLE, cnt=0. While rst_n is low: pc_en=1, ifid_en=1, idex_en=1; all flush/bubble outputs 0; busy=0; stall_cnt=0.
- Default (no event): pc_en=ifid_en=idex_en=1, all others 0.
- Hazard condition, lu = ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)). Register 0 never hazards.
- IDLE priority, highest first:
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_en=1. ex_mc_start and lu are ignored. State stays IDLE.
  2. ex_mc_start with MC_LAT>1: pc_en=ifid_en=idex_en=0, exmem_bubble=1. If MC_LAT>2, go to MC_STALL with cnt=MC_LAT-2. MC_LAT=1 causes no action.
  3. lu: pc_en=ifid_en=0, idex_bubble=1. If LOAD_LAT>1, go to LD_STALL with cnt=LOAD_LAT-1.
- Stall-cycle totals: load-use = LOAD_LAT cycles; multi-cycle op = MC_LAT-1 cycles, counted from the ex_mc_start cycle.
- LD_STALL outputs: pc_en=ifid_en=0, idex_bubble=1.
- MC_STALL outputs: pc_en=ifid_en=idex_en=0, exmem_bubble=1.
- Both stall states: cnt decrements each cycle; when cnt==1, next state is IDLE. All inputs are ignored while in a stall state.
- On the return to IDLE, lu is re-evaluated combinationally. A still-true lu starts a new stall; the datapath guarantees the load has moved on, so this does not occur for legal code.
- Outputs are combinational from state plus inputs. No output asserts later than the cycle of the triggering input.
- busy = (state != IDLE). stall_cnt = cnt.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cycles [CNT_W] and stat_flushes [CNT_W].
  - stat_stall_cycles increments every cycle with pc_en=0.
  - stat_flushes increments every cycle with ifid_flush=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- LOAD_LAT=1: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 for one cycle -> exactly 1 cycle with pc_en=0, idex_bubble=1; busy stays 0.
- LOAD_LAT=3: same hazard -> pc_en=0 for exactly 3 consecutive cycles; stall_cnt reads 2,1 in cycles 2-3; then default outputs.
- MC_LAT=4: ex_mc_start pulse -> idex_en=0 and exmem_bubble=1 for 3 cycles. A branch_taken asserted in cycle 2 is ignored (ifid_flush stays 0).
- Same cycle: ex_branch_taken=1 and a lu hazard -> ifid_flush=1, idex_bubble=1, pc_en=1; no stall follows.
- Hazard on register 0 (ex_rd=0, id_rs=0), and a match with id_use_rs=0 -> no stall.
- MC_LAT=4: assert rst_n=0 during cycle 2 of MC_STALL -> outputs go to their reset values immediately; state=IDLE after release. With HAZARD_STATS_EN defined, both counters read 0.
